// File: rtl/bcd_to_binary.sv
// -----------------------------------------------------------------------------
// bcd_to_binary
//
// Sequential BCD-to-binary converter (reverse double-dabble). The packed BCD
// word and the binary result form one long shift register that is shifted
// right once per iteration. Between shifts, a single shared "digit >= 8 ->
// minus 3" corrector visits the BCD digits one at a time. This trades latency
// for a very small datapath.
//
// Parameters
//   OUTPUT_WIDTH   : binary result width, also the number of shifts
//   DECIMAL_DIGITS : number of packed BCD input digits
//
// Ports
//   i_Clock  : rising-edge clock
//   i_Rst_L  : asynchronous active-low reset
//   i_BCD    : packed BCD input, digit k at [4k+3:4k], digit 0 least significant
//   i_Start  : starts a conversion; only honoured while idle
//   o_Binary : result register, updated only on completion
//   o_DV     : one-cycle pulse when the result is valid
//   o_Busy   : high whenever a conversion is in progress
//   o_Ovf    : decimal value did not fit in OUTPUT_WIDTH bits (held)
//   o_Err    : an input nibble was greater than 9 (held)
//
// Build option
//   BCD_TO_BINARY_CHECK_EN : when defined, the input nibbles are checked at
//   capture and the result is reported on o_Err. When undefined, no check
//   logic is built and o_Err is tied low.
//
// Latency: o_DV rises (OUTPUT_WIDTH-1)*(2+2*DECIMAL_DIGITS)+3 clocks after the
// edge that samples i_Start (685 clocks with the default parameters).
//
// State table
//   state          | meaning
//   ST_IDLE        | waiting for i_Start; capture i_BCD on start
//   ST_SHIFT       | shift {bcd, bin} right by one bit
//   ST_CHECK_SHIFT | last shift done? -> DONE, else run a correction pass
//   ST_SUB         | correct the currently indexed BCD digit
//   ST_CHECK_DIGIT | last digit corrected? -> SHIFT, else next digit
//   ST_DONE        | publish result and flags, pulse o_DV
// -----------------------------------------------------------------------------
module bcd_to_binary #(
  parameter int OUTPUT_WIDTH   = 32,
  parameter int DECIMAL_DIGITS = 10
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_L,
  input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
  input  logic                        i_Start,
  output logic [OUTPUT_WIDTH-1:0]     o_Binary,
  output logic                        o_DV,
  output logic                        o_Busy,
  output logic                        o_Ovf,
  output logic                        o_Err
);

  localparam int BCD_W = DECIMAL_DIGITS * 4;
  localparam int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;

  localparam logic [7:0]       LAST_SHIFT = 8'(OUTPUT_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(DECIMAL_DIGITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SHIFT       = 3'd1,
    ST_CHECK_SHIFT = 3'd2,
    ST_SUB         = 3'd3,
    ST_CHECK_DIGIT = 3'd4,
    ST_DONE        = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BCD_W-1:0]        r_bcd;
  logic [OUTPUT_WIDTH-1:0] r_bin;
  logic [7:0]              loop_cnt;
  logic [IDX_W-1:0]        digit_idx;

  logic [3:0] digit_sel;
  logic [3:0] digit_fix;
  logic       capture;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:        state_nxt = i_Start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT:       state_nxt = ST_CHECK_SHIFT;
      // No correction pass follows the final shift.
      ST_CHECK_SHIFT: state_nxt = (loop_cnt == LAST_SHIFT) ? ST_DONE : ST_SUB;
      ST_SUB:         state_nxt = ST_CHECK_DIGIT;
      ST_CHECK_DIGIT: state_nxt = (digit_idx == LAST_DIGIT) ? ST_SHIFT : ST_SUB;
      ST_DONE:        state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    o_Busy  = (state != ST_IDLE);
    capture = (state == ST_IDLE) && i_Start;
  end

  // ---------------------------------------------------------------------------
  // Shared digit corrector: one 4-bit compare and subtract, time-multiplexed
  // over the digits by digit_idx. No borrow crosses digit boundaries.
  // ---------------------------------------------------------------------------
  always_comb begin
    digit_sel = r_bcd[{digit_idx, 2'b00} +: 4];
    digit_fix = (digit_sel >= 4'd8) ? (digit_sel - 4'd3) : digit_sel;
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_bcd     <= '0;
      r_bin     <= '0;
      loop_cnt  <= '0;
      digit_idx <= '0;
      o_Binary  <= '0;
      o_Ovf     <= 1'b0;
      o_DV      <= 1'b0;
    end else begin
      o_DV <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (capture) begin
            r_bcd     <= i_BCD;
            r_bin     <= '0;
            loop_cnt  <= '0;
            digit_idx <= '0;
          end
        end
        ST_SHIFT: begin
          {r_bcd, r_bin} <= {r_bcd, r_bin} >> 1;
        end
        ST_CHECK_SHIFT: begin
          if (loop_cnt == LAST_SHIFT) begin
            loop_cnt <= '0;
          end else begin
            loop_cnt <= loop_cnt + 8'd1;
          end
        end
        ST_SUB: begin
          r_bcd[{digit_idx, 2'b00} +: 4] <= digit_fix;
        end
        ST_CHECK_DIGIT: begin
          if (digit_idx == LAST_DIGIT) begin
            digit_idx <= '0;
          end else begin
            digit_idx <= digit_idx + 1'b1;
          end
        end
        ST_DONE: begin
          o_Binary <= r_bin;
          // Anything left in the BCD half after the last shift is the part
          // of the value above 2^OUTPUT_WIDTH.
          o_Ovf    <= |r_bcd;
          o_DV     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional invalid-digit check
  // ---------------------------------------------------------------------------
`ifdef BCD_TO_BINARY_CHECK_EN
  logic bcd_invalid;
  logic r_err;

  always_comb begin
    bcd_invalid = 1'b0;
    for (int k = 0; k < DECIMAL_DIGITS; k++) begin
      if (i_BCD[k*4 +: 4] > 4'd9) begin
        bcd_invalid = 1'b1;
      end
    end
  end

  // Flag is taken at capture time; later i_BCD changes do not affect it.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_err <= 1'b0;
      o_Err <= 1'b0;
    end else begin
      if (capture) begin
        r_err <= bcd_invalid;
      end
      if (state == ST_DONE) begin
        o_Err <= r_err;
      end
    end
  end
`else
  assign o_Err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

  localparam int LAT_MAIN  = 685;  // (32-1)*(2+2*10)+3
  localparam int LAT_SMALL = 183;  // (16-1)*(2+2*5)+3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [39:0] bcd;
  logic        start;
  logic [31:0] o_bin;
  logic        o_dv, o_busy, o_ovf, o_err;

  logic [19:0] s_bcd;
  logic        s_start;
  logic [15:0] s_bin;
  logic        s_dv, s_busy, s_ovf, s_err;

  bcd_to_binary #(.OUTPUT_WIDTH(32), .DECIMAL_DIGITS(10)) dut (
    .i_Clock (clk),
    .i_Rst_L (rst_n),
    .i_BCD   (bcd),
    .i_Start (start),
    .o_Binary(o_bin),
    .o_DV    (o_dv),
    .o_Busy  (o_busy),
    .o_Ovf   (o_ovf),
    .o_Err   (o_err)
  );

  bcd_to_binary #(.OUTPUT_WIDTH(16), .DECIMAL_DIGITS(5)) dut_small (
    .i_Clock (clk),
    .i_Rst_L (rst_n),
    .i_BCD   (s_bcd),
    .i_Start (s_start),
    .o_Binary(s_bin),
    .o_DV    (s_dv),
    .o_Busy  (s_busy),
    .o_Ovf   (s_ovf),
    .o_Err   (s_err)
  );

  typedef struct {
    logic [31:0] bin;
    logic        ovf;
    logic        err;
    logic        chk_bin;
    int          start_cyc;
  } exp_t;

  exp_t q[$];
  exp_t sq[$];
  exp_t mon_e;
  exp_t smon_e;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Decimal value of a packed BCD word (nd digits), independent of the DUT.
  function automatic logic [63:0] bcd_val(input logic [39:0] v, input int nd);
    logic [63:0] acc;
    acc = 64'd0;
    for (int k = nd - 1; k >= 0; k--) begin
      acc = acc * 64'd10 + 64'(v[k*4 +: 4]);
    end
    return acc;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitors: pop the oldest expectation whenever a result is presented
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && o_dv) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dv actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        check("latency", 64'(cyc - mon_e.start_cyc), 64'(LAT_MAIN));
        if (mon_e.chk_bin) check("binary", 64'(o_bin), 64'(mon_e.bin));
        check("ovf", 64'(o_ovf), 64'(mon_e.ovf));
        check("err", 64'(o_err), 64'(mon_e.err));
        check("busy_at_dv", 64'(o_busy), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_dv) begin
      if (sq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL small_unexpected_dv actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        smon_e = sq.pop_front();
        check("small_latency", 64'(cyc - smon_e.start_cyc), 64'(LAT_SMALL));
        check("small_binary", 64'(s_bin), 64'(smon_e.bin));
        check("small_ovf", 64'(s_ovf), 64'(smon_e.ovf));
        check("small_err", 64'(s_err), 64'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic start_conv(input logic [39:0] v, input logic [31:0] eb,
                            input logic eo, input logic ee, input logic cb);
    exp_t e;
    e.bin       = eb;
    e.ovf       = eo;
    e.err       = ee;
    e.chk_bin   = cb;
    e.start_cyc = cyc + 1;
    bcd   = v;
    start = 1'b1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", 64'(o_busy), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout actual=busy required=idle (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_dv();
    int n = 0;
    while (!o_dv && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!o_dv) begin
      checks++;
      failures++;
      $display("FAIL wait_dv_timeout actual=0 required=1 (cycle %0d)", cyc);
    end
  endtask

  task automatic small_conv(input logic [19:0] v);
    exp_t        e;
    logic [63:0] val;
    int          n;
    val         = bcd_val({20'd0, v}, 5);
    e.bin       = {16'd0, val[15:0]};
    e.ovf       = (val >= 64'd65536);
    e.err       = 1'b0;
    e.chk_bin   = 1'b1;
    e.start_cyc = cyc + 1;
    s_bcd   = v;
    s_start = 1'b1;
    sq.push_back(e);
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (s_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (s_busy) begin
      checks++;
      failures++;
      $display("FAIL small_timeout actual=busy required=idle (cycle %0d)", cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [39:0] rv;
    logic [19:0] srv;
    logic [63:0] val;

    rst_n   = 1'b0;
    start   = 1'b0;
    bcd     = '0;
    s_start = 1'b0;
    s_bcd   = '0;
    repeat (3) @(negedge clk);
    check("rst_binary", 64'(o_bin), 64'd0);
    check("rst_dv", 64'(o_dv), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_ovf", 64'(o_ovf), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic conversion, then back-to-back start in the o_DV cycle.
    start_conv(40'h0000000255, 32'h000000FF, 1'b0, 1'b0, 1'b1);
    wait_dv();
    start_conv(40'h0000000042, 32'h0000002A, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Boundaries.
    start_conv(40'h4294967295, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    wait_idle();
    start_conv(40'h4294967296, 32'h00000000, 1'b1, 1'b0, 1'b1);
    wait_idle();
    start_conv(40'h0000000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Start and input changes while busy are ignored.
    start_conv(40'h0000000789, 32'h00000315, 1'b0, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    bcd   = 40'h0000000100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcd   = 40'h0000000099;
    wait_idle();

    // Reset mid-conversion: outputs clear at once, no result is produced.
    bcd   = 40'h9999999999;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_binary", 64'(o_bin), 64'd0);
    check("abort_dv", 64'(o_dv), 64'd0);
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_ovf", 64'(o_ovf), 64'd0);
    check("abort_err", 64'(o_err), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_busy", 64'(o_busy), 64'd0);
    start_conv(40'h0000001234, 32'h000004D2, 1'b0, 1'b0, 1'b1);
    wait_idle();

`ifdef BCD_TO_BINARY_CHECK_EN
    start_conv(40'h000000001A, 32'h00000000, 1'b0, 1'b1, 1'b0);
    wait_idle();
    start_conv(40'h0000000019, 32'h00000013, 1'b0, 1'b0, 1'b1);
    wait_idle();
`endif

    // Random valid BCD on the default-size instance.
    for (int i = 0; i < 8; i++) begin
      rv = '0;
      for (int k = 0; k < 10; k++) rv[k*4 +: 4] = 4'($urandom_range(0, 9));
      val = bcd_val(rv, 10);
      start_conv(rv, val[31:0], (val >= 64'h1_0000_0000), 1'b0, 1'b1);
      wait_idle();
    end

    // Random valid BCD on the 16-bit / 5-digit instance.
    for (int i = 0; i < 30; i++) begin
      srv = '0;
      for (int k = 0; k < 5; k++) srv[k*4 +: 4] = 4'($urandom_range(0, 9));
      small_conv(srv);
    end
    small_conv(20'h65535);
    small_conv(20'h65536);

    repeat (3) @(negedge clk);
    check("main_queue_drained", 64'(q.size()), 64'd0);
    check("small_queue_drained", 64'(sq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
